// File: rtl/mac_if.sv
// Handshake and result bundle between the 2x2 multiplier/controller and mac_accumulator.
// valid/ready: a product transfers on a rising edge where prod_valid && prod_ready;
// the master holds prod_in stable while prod_valid is high and prod_ready is low.
interface mac_if #(
    parameter int PROD_W = 4,
    parameter int ACC_W  = 8
);
    logic              start;
    logic [3:0]        len;
    logic [PROD_W-1:0] prod_in;
    logic              prod_valid;
    logic              prod_ready;
    logic [ACC_W-1:0]  acc_out;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [1:0]        state_dbg;

    modport master (
        output start, len, prod_in, prod_valid,
        input  prod_ready, acc_out, busy, done, overflow, state_dbg
    );

    modport slave (
        input  start, len, prod_in, prod_valid,
        output prod_ready, acc_out, busy, done, overflow, state_dbg
    );
endinterface

// File: rtl/mac_accumulator.sv
// Sums a programmed number of unsigned products into a wider register with a sticky overflow flag.
// Optional MAC_ACC_SATURATE_EN: clamp the result at the maximum on carry-out instead of wrapping.
module mac_accumulator #(
    parameter int PROD_W = 4,
    parameter int ACC_W  = 8
) (
    input  logic clk,
    input  logic rst,
    mac_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [3:0]       rem;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;

    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] next_acc;

    always_comb begin
        sum = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.prod_in};
`ifdef MAC_ACC_SATURATE_EN
        // Once clamped, the result stays pinned at the maximum for the rest of the run.
        next_acc = (sum[ACC_W] || ovf) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
        next_acc = sum[ACC_W-1:0];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rem     <= '0;
            acc     <= '0;
            ovf     <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        rem    <= bus.len;
                        acc    <= '0;
                        ovf    <= 1'b0;
                        busy_q <= 1'b1;
                        if (bus.len == 4'd0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state   <= ACCUM;
                            ready_q <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (bus.prod_valid) begin
                        acc <= next_acc;
                        ovf <= ovf | sum[ACC_W];
                        rem <= rem - 4'd1;
                        if (rem == 4'd1) begin
                            state   <= DONE;
                            ready_q <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.prod_ready = ready_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.acc_out    = acc;
    assign bus.overflow   = ovf;
    assign bus.state_dbg  = state;
endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: an 8-bit and a 6-bit accumulator driven by identical stimulus.
// Expected sums are queued when a run is launched and popped when done is observed.
module tb_mac_accumulator;
    localparam int RUN_BUDGET = 80;

    logic clk;
    logic rst;
    logic       start;
    logic [3:0] len;
    logic [3:0] prod_in;
    logic       prod_valid;

    logic [3:0] vals [16];

    logic [7:0] exp_q [$];
    logic       eovf_q [$];
    logic [5:0] oexp_q [$];
    logic       oeovf_q [$];

    int n_cmp;
    int n_err;

    mac_if #(.PROD_W(4), .ACC_W(8)) bus ();
    mac_if #(.PROD_W(4), .ACC_W(6)) obus ();

    mac_accumulator #(.PROD_W(4), .ACC_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mac_accumulator #(.PROD_W(4), .ACC_W(6)) dut6 (
        .clk (clk),
        .rst (rst),
        .bus (obus)
    );

    assign bus.start       = start;
    assign bus.len         = len;
    assign bus.prod_in     = prod_in;
    assign bus.prod_valid  = prod_valid;
    assign obus.start      = start;
    assign obus.len        = len;
    assign obus.prod_in    = prod_in;
    assign obus.prod_valid = prod_valid;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference sum over vals[0..n-1] at width w; returns {overflow, sum}.
    function automatic logic [8:0] ref_sum(input int n, input int w);
        int   acc;
        int   lim;
        logic ov;
        acc = 0;
        ov  = 1'b0;
        lim = 1 << w;
        for (int i = 0; i < n; i++) begin
            acc += int'(vals[i]);
            if (acc >= lim) begin
                ov = 1'b1;
`ifdef MAC_ACC_SATURATE_EN
                acc = lim - 1;
`else
                acc -= lim;
`endif
            end
        end
        return {ov, acc[7:0]};
    endfunction

    // Launches a run at a falling edge and feeds products with `gap` idle cycles between
    // transfers; returns the cycle (counted from the start cycle) on which done was seen.
    task automatic drive_run(input int n, input int gap, input bit start_mid,
                             output int done_cyc, output logic [7:0] acc_seen,
                             output logic ovf_seen, output logic [5:0] oacc_seen,
                             output logic oovf_seen, output int ctrl_bad);
        int idx;
        int gap_cnt;
        bit ready_prev;
        bit found;
        idx = 0; gap_cnt = 0; found = 0;
        done_cyc = -1; ctrl_bad = 0;
        acc_seen = '0; ovf_seen = 1'b0; oacc_seen = '0; oovf_seen = 1'b0;
        @(negedge clk);
        start      = 1'b1;
        len        = n[3:0];
        prod_valid = (n > 0);
        prod_in    = vals[0];
        ready_prev = bus.prod_ready;
        for (int cyc = 1; cyc <= RUN_BUDGET && !found; cyc++) begin
            @(negedge clk);
            start = start_mid && (cyc == 1);
            if (start_mid) len = 4'd9;
            if (bus.done) begin
                found     = 1;
                done_cyc  = cyc;
                acc_seen  = bus.acc_out;
                ovf_seen  = bus.overflow;
                oacc_seen = obus.acc_out;
                oovf_seen = obus.overflow;
                if (bus.prod_ready !== 1'b0) ctrl_bad++;
                if (bus.busy !== 1'b1) ctrl_bad++;
            end else begin
                if (bus.prod_ready !== (n > 0)) ctrl_bad++;
                if (bus.busy !== 1'b1) ctrl_bad++;
                if (prod_valid && ready_prev) begin
                    idx++;
                    gap_cnt = gap;
                end
                if (idx < n && gap_cnt == 0) begin
                    prod_valid = 1'b1;
                    prod_in    = vals[idx];
                end else begin
                    prod_valid = 1'b0;
                    if (gap_cnt > 0) gap_cnt--;
                end
                ready_prev = bus.prod_ready;
            end
        end
        start      = 1'b0;
        prod_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; len = '0; prod_in = '0; prod_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.acc_out !== 8'd0 || bus.overflow !== 1'b0 || bus.done !== 1'b0 ||
            bus.busy !== 1'b0 || bus.prod_ready !== 1'b0 || bus.state_dbg !== 2'd0) begin
            n_err++;
            $display("FAIL reset_state: acc=%0h ovf=%b done=%b busy=%b ready=%b st=%0d required 0s",
                     bus.acc_out, bus.overflow, bus.done, bus.busy, bus.prod_ready, bus.state_dbg);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.acc_out !== 8'd0) begin
            n_err++;
            $display("FAIL reset_release: busy=%b acc=%0d required 0/0", bus.busy, bus.acc_out);
        end
    endtask

    task automatic test_basic();
        int dc; int cb; logic [7:0] a; logic ov; logic [5:0] oa; logic oov;
        logic [8:0] m;
        vals[0] = 4'd1; vals[1] = 4'd4; vals[2] = 4'd9;
        m = ref_sum(3, 8);
        exp_q.push_back(m[7:0]); eovf_q.push_back(m[8]);
        drive_run(3, 0, 0, dc, a, ov, oa, oov, cb);
        n_cmp++;
        if (dc !== 4) begin n_err++; $display("FAIL basic_done_cycle: got %0d required 4", dc); end
        m[7:0] = exp_q.pop_front(); m[8] = eovf_q.pop_front();
        n_cmp++;
        if (a !== m[7:0]) begin n_err++; $display("FAIL basic_sum: got %0d required %0d", a, m[7:0]); end
        n_cmp++;
        if (ov !== m[8]) begin n_err++; $display("FAIL basic_overflow: got %b required %b", ov, m[8]); end
        n_cmp++;
        if (cb !== 0) begin n_err++; $display("FAIL basic_ctrl: %0d bad ready/busy cycles required 0", cb); end
    endtask

    task automatic test_stall();
        int dc; int cb; logic [7:0] a; logic ov; logic [5:0] oa; logic oov;
        logic [8:0] m;
        vals[0] = 4'd6; vals[1] = 4'd9;
        m = ref_sum(2, 8);
        exp_q.push_back(m[7:0]); eovf_q.push_back(m[8]);
        drive_run(2, 3, 0, dc, a, ov, oa, oov, cb);
        n_cmp++;
        if (dc !== 6) begin n_err++; $display("FAIL stall_done_cycle: got %0d required 6", dc); end
        m[7:0] = exp_q.pop_front(); m[8] = eovf_q.pop_front();
        n_cmp++;
        if (a !== m[7:0]) begin n_err++; $display("FAIL stall_sum: got %0d required %0d", a, m[7:0]); end
        n_cmp++;
        if (cb !== 0) begin n_err++; $display("FAIL stall_ready: %0d bad ready/busy cycles required 0", cb); end
    endtask

    task automatic test_zero_len();
        int dc; int cb; logic [7:0] a; logic ov; logic [5:0] oa; logic oov;
        exp_q.push_back(8'd0);
        drive_run(0, 0, 0, dc, a, ov, oa, oov, cb);
        n_cmp++;
        if (dc !== 1) begin n_err++; $display("FAIL zero_done_cycle: got %0d required 1", dc); end
        n_cmp++;
        if (a !== exp_q.pop_front()) begin n_err++; $display("FAIL zero_sum: got %0d required 0", a); end
        n_cmp++;
        if (cb !== 0) begin n_err++; $display("FAIL zero_ready: %0d bad ready/busy cycles required 0", cb); end
    endtask

    task automatic test_overflow();
        int dc; int cb; logic [7:0] a; logic ov; logic [5:0] oa; logic oov;
        logic [8:0] m;
        for (int i = 0; i < 16; i++) vals[i] = 4'd9;
        m = ref_sum(15, 8);
        exp_q.push_back(m[7:0]); eovf_q.push_back(m[8]);
`ifdef MAC_ACC_SATURATE_EN
        oexp_q.push_back(6'd63);
`else
        oexp_q.push_back(6'd7);
`endif
        oeovf_q.push_back(1'b1);
        drive_run(15, 0, 0, dc, a, ov, oa, oov, cb);
        n_cmp++;
        if (dc !== 16) begin n_err++; $display("FAIL ovf_done_cycle: got %0d required 16", dc); end
        m[7:0] = exp_q.pop_front(); m[8] = eovf_q.pop_front();
        n_cmp++;
        if (a !== m[7:0] || ov !== m[8]) begin
            n_err++;
            $display("FAIL ovf_wide_sum: got %0d/%b required %0d/%b", a, ov, m[7:0], m[8]);
        end
        m[5:0] = oexp_q.pop_front(); m[8] = oeovf_q.pop_front();
        n_cmp++;
        if (oa !== m[5:0]) begin n_err++; $display("FAIL ovf_narrow_sum: got %0d required %0d", oa, m[5:0]); end
        n_cmp++;
        if (oov !== m[8]) begin n_err++; $display("FAIL ovf_narrow_flag: got %b required %b", oov, m[8]); end
        @(negedge clk);
        n_cmp++;
        if (obus.overflow !== 1'b1 || obus.acc_out !== m[5:0]) begin
            n_err++;
            $display("FAIL ovf_hold_idle: got %0d/%b required %0d/1", obus.acc_out, obus.overflow, m[5:0]);
        end
    endtask

    task automatic test_ignored_start();
        int dc; int cb; logic [7:0] a; logic ov; logic [5:0] oa; logic oov;
        logic [8:0] m;
        vals[0] = 4'd3; vals[1] = 4'd3;
        m = ref_sum(2, 6);
        oexp_q.push_back(m[5:0]); oeovf_q.push_back(m[8]);
        drive_run(2, 0, 1, dc, a, ov, oa, oov, cb);
        n_cmp++;
        if (dc !== 3) begin n_err++; $display("FAIL ign_done_cycle: got %0d required 3", dc); end
        m[5:0] = oexp_q.pop_front(); m[8] = oeovf_q.pop_front();
        n_cmp++;
        if (oa !== m[5:0] || a !== {2'b00, m[5:0]}) begin
            n_err++;
            $display("FAIL ign_sum: got %0d/%0d required %0d", a, oa, m[5:0]);
        end
        n_cmp++;
        if (oov !== m[8]) begin n_err++; $display("FAIL ign_ovf_cleared: got %b required %b", oov, m[8]); end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_err++; $display("FAIL ign_no_restart: busy=%b required 0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        int dc; int cb; logic [7:0] a; logic ov; logic [5:0] oa; logic oov;
        logic [8:0] m;
        vals[0] = 4'd5; vals[1] = 4'd7;
        m = ref_sum(2, 8);
        exp_q.push_back(m[7:0]);
        drive_run(2, 0, 0, dc, a, ov, oa, oov, cb);
        n_cmp++;
        if (dc !== 3 || a !== exp_q.pop_front()) begin
            n_err++;
            $display("FAIL b2b_first: cycle %0d sum %0d required 3 / %0d", dc, a, m[7:0]);
        end
        vals[0] = 4'd15;
        m = ref_sum(1, 8);
        exp_q.push_back(m[7:0]);
        drive_run(1, 0, 0, dc, a, ov, oa, oov, cb);
        n_cmp++;
        if (dc !== 2 || a !== exp_q.pop_front()) begin
            n_err++;
            $display("FAIL b2b_second: cycle %0d sum %0d required 2 / %0d", dc, a, m[7:0]);
        end
        n_cmp++;
        if (cb !== 0) begin n_err++; $display("FAIL b2b_ctrl: %0d bad ready/busy cycles required 0", cb); end
    endtask

    task automatic test_reset_mid_run();
        bit done_seen;
        done_seen = 0;
        @(negedge clk);
        start = 1'b1; len = 4'd5; prod_valid = 1'b1; prod_in = 4'd2;
        @(negedge clk);
        start = 1'b0;
        done_seen |= bus.done;
        repeat (2) begin
            @(negedge clk);
            done_seen |= bus.done;
        end
        n_cmp++;
        if (bus.acc_out !== 8'd4) begin n_err++; $display("FAIL rst_mid_pre: acc=%0d required 4", bus.acc_out); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.acc_out !== 8'd0 || bus.busy !== 1'b0 || bus.prod_ready !== 1'b0 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_abort: acc=%0d busy=%b ready=%b done=%b required 0s",
                     bus.acc_out, bus.busy, bus.prod_ready, bus.done);
        end
        rst = 1'b0; prod_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            done_seen |= bus.done;
        end
        n_cmp++;
        if (done_seen || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_no_done: done_seen=%b busy=%b required 0/0", done_seen, bus.busy);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_stall();
        test_zero_len();
        test_overflow();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Sequential accumulation stage directly downstream of the 2x2 multiplier. It accepts a programmed number of 4-bit products over a valid/ready handshake and sums them into a wider register. When the last term is accepted it raises a one-cycle `done` and holds the result. Together with the multiplier it forms the multiply-accumulate datapath.

## Interface
- `PROD_W`, default 4: product input width; matches the 2x2 multiplier output.
- `ACC_W`, default 8: accumulator width; must be ≥ `PROD_W`.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `start`  in  1: begin a new accumulation; honoured only in IDLE.
- `len`  in  4: number of products to sum; sampled when `start` is honoured.
- `prod_in`  in  PROD_W: product from the multiplier, unsigned.
- `prod_valid`  in  1: `prod_in` is valid.
- `prod_ready`  out  1: block accepts a product this cycle.
- `acc_out`  out  ACC_W: accumulated sum, registered.
- `busy`  out  1: a run is in progress (state ≠ IDLE).
- `done`  out  1: one-cycle pulse when the run completes.
- `overflow`  out  1: sticky flag; set if any addition exceeded ACC_W bits during the run.

## Operation
- FSM states: IDLE, ACCUM, DONE. Reset state is IDLE.
- IDLE, on `start`:
  - latch `len` into remaining-count `rem`; clear `acc_out` to 0 and `overflow` to 0.
  - if `len` = 0, go to DONE; otherwise go to ACCUM.
- IDLE without `start`: `acc_out` and `overflow` hold their last values.
- ACCUM:
  - `prod_ready` = 1.
  - On each cycle with `prod_valid` = 1: `acc_out` ← `acc_out` + zero-extend(`prod_in`), and `rem` ← `rem` − 1.
  - When the accepted term has `rem` = 1, go to DONE.
  - `prod_valid` = 0 stalls the run with no change to state.
- DONE: `done` = 1 for exactly this cycle, then go to IDLE unconditionally.
- `prod_ready` = 0 in IDLE and DONE. Products offered there are not consumed; the upstream must hold them.
- `start` in ACCUM or DONE is ignored; no restart mid-run.
- Addition is performed at ACC_W+1 bits. A carry out of bit ACC_W−1 sets `overflow`, which stays set until the next honoured `start`.
- Result on carry-out, without the saturation feature: the result wraps modulo 2^ACC_W.
- `busy` = 1 in ACCUM and DONE.
- Reset values: `acc_out` = 0, `overflow` = 0, `done` = 0, `busy` = 0, `prod_ready` = 0, `rem` = 0.
- `rst` asserted mid-run aborts immediately to IDLE with the reset values above. No `done` pulse is produced.

## Timing
- `prod_ready`, `busy`, `done` are decoded from registered state only; there is no combinational path from any input.
- A transfer occurs on the rising edge where `prod_valid` && `prod_ready`. `acc_out` reflects that term on the following cycle.
- `done` is asserted the cycle after the last transfer. `acc_out` is final and stable in that same cycle.
- Minimum run with `len` = N > 0 and `prod_valid` held high: `start` edge, then N transfer cycles, then one DONE cycle. Total N+2 cycles from `start` to back in IDLE.
- `len` = 0: `done` one cycle after the `start` edge, with `acc_out` = 0.
- Back-to-back runs: `start` may be asserted in the first IDLE cycle after DONE.

## Configuration
- `MAC_ACC_SATURATE_EN` defined: on carry-out, `acc_out` clamps to 2^ACC_W − 1 and stays clamped for the rest of the run. Further additions keep it at the maximum. `overflow` is still set.
- Not defined: the result wraps modulo 2^ACC_W, and `overflow` is set as described above.

## Test plan
- Reset mid-run: `len`=5, `rst` after 2 transfers → next cycle `acc_out`=0, `busy`=0, no `done` pulse.
- Basic sum: `len`=3, products 1, 4, 9 back-to-back → `done` 4 cycles after `start`, `acc_out`=14, `overflow`=0.
- Stalls: `len`=2, products 6, 9 with 3 idle cycles between them → `acc_out`=15, `prod_ready` high throughout ACCUM, `done` the cycle after the 9 is accepted.
- Zero length: `len`=0 → `done` one cycle after `start`, `acc_out`=0, `prod_ready` never asserted.
- Overflow: `ACC_W`=6, `len`=15, all products 9.
  - Without `MAC_ACC_SATURATE_EN`: `acc_out`=7 (135 mod 64), `overflow`=1.
  - With `MAC_ACC_SATURATE_EN`: `acc_out`=63, `overflow`=1.
- Ignored start: `start` pulsed in ACCUM with `len`=9 during a `len`=2 run (products 3, 3) → `acc_out`=6, `done` after 2 terms.
